trap_ctrl: RTL

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_if.sv | 46 ++++
 rtl/trap_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl_if.sv
// Trap controller bus: exception/interrupt requests, CSR snapshots,
// the shared CSR write port and pipeline control outputs.
interface trap_ctrl_if #(
  parameter int DW = 64
);
  logic          exp_req_i;
  logic [3:0]    exp_cause_i;
  logic [DW-1:0] exp_pc_i;
  logic [DW-1:0] exp_tval_i;
  logic          mret_i;
  logic          ext_irq_i;
  logic          sft_irq_i;
  logic          tmr_irq_i;
  logic          int_ok_i;
  logic [DW-1:0] int_pc_i;
  logic [DW-1:0] csr_mstatus_i;
  logic [DW-1:0] csr_mie_i;
  logic [DW-1:0] csr_mtvec_i;
  logic [DW-1:0] csr_mepc_i;
  logic          ex_we_i;
  logic          clt_we_o;
  logic [11:0]   clt_addr_o;
  logic [DW-1:0] clt_data_o;
  logic          stall_o;
  logic          flush_o;
  logic          jump_o;
  logic [DW-1:0] jump_pc_o;

  // Pipeline / CSR-file side
  modport master (
    output exp_req_i, exp_cause_i, exp_pc_i, exp_tval_i, mret_i,
           ext_irq_i, sft_irq_i, tmr_irq_i, int_ok_i, int_pc_i,
           csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i, ex_we_i,
    input  clt_we_o, clt_addr_o, clt_data_o, stall_o, flush_o,
           jump_o, jump_pc_o
  );

  // Trap controller side
  modport slave (
    input  exp_req_i, exp_cause_i, exp_pc_i, exp_tval_i, mret_i,
           ext_irq_i, sft_irq_i, tmr_irq_i, int_ok_i, int_pc_i,
           csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i, ex_we_i,
    output clt_we_o, clt_addr_o, clt_data_o, stall_o, flush_o,
           jump_o, jump_pc_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates exceptions, MRET and interrupts,
// sequences the mepc/mcause/mtval/mstatus CSR writes over a write port
// shared with EX (EX wins), then redirects the pipeline.
module trap_ctrl #(
  parameter int DW = 64
) (
  input logic        clk,
  input logic        rst,
  trap_ctrl_if.slave bus
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTAT, R_MSTAT, JUMP
  } state_t;

  state_t        state;
  logic          is_int;
  logic          is_mret;
  logic [3:0]    cause_q;
  logic [DW-1:0] pc_q;
  logic [DW-1:0] tval_q;
  logic [DW-1:0] mstat_q;

  logic          irq_gate;
  logic          ext_take;
  logic          sft_take;
  logic          tmr_take;
  logic          accept;
  logic          wr_state;
  logic [DW-1:0] trap_mstat;
  logic [DW-1:0] mret_mstat;
  logic [DW-1:0] tvec_base;
  logic [DW-1:0] trap_target;

  // Interrupt qualification and IDLE acceptance
  always_comb begin
    irq_gate = bus.csr_mstatus_i[3] & bus.int_ok_i;
    ext_take = irq_gate & bus.csr_mie_i[11] & bus.ext_irq_i;
    sft_take = irq_gate & bus.csr_mie_i[3]  & bus.sft_irq_i;
    tmr_take = irq_gate & bus.csr_mie_i[7]  & bus.tmr_irq_i;
    accept   = (state == IDLE) &
               (bus.exp_req_i | bus.mret_i | ext_take | sft_take | tmr_take);
  end

  // FSM and trap context latches; write states only advance when EX is not using the port
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      is_int  <= 1'b0;
      is_mret <= 1'b0;
      cause_q <= '0;
      pc_q    <= '0;
      tval_q  <= '0;
      mstat_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.exp_req_i) begin
            is_int  <= 1'b0;
            is_mret <= 1'b0;
            cause_q <= bus.exp_cause_i;
            pc_q    <= bus.exp_pc_i;
            tval_q  <= bus.exp_tval_i;
            mstat_q <= bus.csr_mstatus_i;
            state   <= W_MEPC;
          end else if (bus.mret_i) begin
            is_int  <= 1'b0;
            is_mret <= 1'b1;
            mstat_q <= bus.csr_mstatus_i;
            state   <= R_MSTAT;
          end else if (ext_take | sft_take | tmr_take) begin
            is_int  <= 1'b1;
            is_mret <= 1'b0;
            cause_q <= ext_take ? 4'd11 : (sft_take ? 4'd3 : 4'd7);
            pc_q    <= bus.int_pc_i;
            tval_q  <= '0;
            mstat_q <= bus.csr_mstatus_i;
            state   <= W_MEPC;
          end
        end
        W_MEPC:   if (!bus.ex_we_i) state <= W_MCAUSE;
        W_MCAUSE: if (!bus.ex_we_i) state <= W_MTVAL;
        W_MTVAL:  if (!bus.ex_we_i) state <= W_MSTAT;
        W_MSTAT:  if (!bus.ex_we_i) state <= JUMP;
        R_MSTAT:  if (!bus.ex_we_i) state <= JUMP;
        JUMP:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // mstatus images for trap entry / MRET and the trap vector target
  always_comb begin
    trap_mstat        = mstat_q;
    trap_mstat[7]     = mstat_q[3];
    trap_mstat[3]     = 1'b0;
    trap_mstat[12:11] = 2'b11;
    mret_mstat        = mstat_q;
    mret_mstat[3]     = mstat_q[7];
    mret_mstat[7]     = 1'b1;
    tvec_base         = {bus.csr_mtvec_i[DW-1:2], 2'b00};
    if (is_int && (bus.csr_mtvec_i[1:0] == 2'b01))
      trap_target = tvec_base + {{(DW-6){1'b0}}, cause_q, 2'b00};
    else
      trap_target = tvec_base;
  end

  // Output decode; stall/flush include the IDLE acceptance cycle, everything is held at zero in reset
  always_comb begin
    bus.clt_we_o   = 1'b0;
    bus.clt_addr_o = '0;
    bus.clt_data_o = '0;
    bus.stall_o    = 1'b0;
    bus.flush_o    = 1'b0;
    bus.jump_o     = 1'b0;
    bus.jump_pc_o  = '0;
    wr_state       = 1'b0;
    if (!rst) begin
      bus.stall_o = accept | (state != IDLE);
      bus.flush_o = accept | (state == JUMP);
      case (state)
        W_MEPC: begin
          wr_state       = 1'b1;
          bus.clt_addr_o = CSR_MEPC;
          bus.clt_data_o = {pc_q[DW-1:2], 2'b00};
        end
        W_MCAUSE: begin
          wr_state       = 1'b1;
          bus.clt_addr_o = CSR_MCAUSE;
          bus.clt_data_o = {is_int, {(DW-5){1'b0}}, cause_q};
        end
        W_MTVAL: begin
          wr_state       = 1'b1;
          bus.clt_addr_o = CSR_MTVAL;
          bus.clt_data_o = tval_q;
        end
        W_MSTAT: begin
          wr_state       = 1'b1;
          bus.clt_addr_o = CSR_MSTATUS;
          bus.clt_data_o = trap_mstat;
        end
        R_MSTAT: begin
          wr_state       = 1'b1;
          bus.clt_addr_o = CSR_MSTATUS;
          bus.clt_data_o = mret_mstat;
        end
        JUMP: begin
          bus.jump_o    = 1'b1;
          bus.jump_pc_o = is_mret ? {bus.csr_mepc_i[DW-1:2], 2'b00} : trap_target;
        end
        default: ;
      endcase
      bus.clt_we_o = wr_state & ~bus.ex_we_i;
    end
  end

endmodule
